// File: rtl/hash_target_checker_pkg.sv
// Shared types and constants for the hash target checker and the hash top level.
// Holds the scan FSM state type and the default scan length.
package hash_target_checker_pkg;

    localparam int NUM_NONCES_DEFAULT = 16;
    localparam int OFFSET_W           = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage : hash_target_checker_pkg

// File: rtl/hash_target_checker.sv
// Scans NUM_NONCES consecutive hash words from memory and reports which fall below
// a difficulty target, the lowest such nonce, and the minimum hash seen.
module hash_target_checker
    import hash_target_checker_pkg::*;
#(
    parameter int NUM_NONCES = NUM_NONCES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [3:0]  nonce_idx,
    output logic [31:0] best_hash,
    output logic [3:0]  best_idx,
    output logic [4:0]  hit_count,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output state_e      dbg_state
);

    localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(NUM_NONCES);

    // Handshake: start is a one-cycle request honoured only while done is high;
    // done falls on the accepting edge and rises once every word has been compared.
    state_e               state;
    state_e               next_state;
    logic                 load;
    logic                 compare_en;
    logic [15:0]          base;
    logic [31:0]          target_q;
    logic [OFFSET_W-1:0]  offset;
    logic [OFFSET_W-1:0]  word_idx;
    logic                 hit;
    logic                 better;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SCAN;
                    load       = 1'b1;
                end
            end
            SCAN: begin
                if (offset == LAST_OFFSET) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so offset j carries word j-1.
    assign compare_en = (state == SCAN) && (offset != '0);
    assign word_idx   = offset - OFFSET_W'(1);
    assign hit        = mem_read_data < target_q;
    assign better     = mem_read_data < best_hash;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base      <= '0;
            target_q  <= '0;
            offset    <= '0;
            found     <= 1'b0;
            nonce_idx <= '0;
            best_hash <= 32'hFFFF_FFFF;
            best_idx  <= '0;
            hit_count <= '0;
        end else if (load) begin
            base      <= hash_addr;
            target_q  <= target;
            offset    <= '0;
            found     <= 1'b0;
            nonce_idx <= '0;
            best_hash <= 32'hFFFF_FFFF;
            best_idx  <= '0;
            hit_count <= '0;
        end else if (state == SCAN) begin
            offset <= (offset == LAST_OFFSET) ? '0 : offset + OFFSET_W'(1);
            if (compare_en) begin
                if (hit) begin
                    hit_count <= hit_count + 5'd1;
                    if (!found) begin
                        found     <= 1'b1;
                        nonce_idx <= word_idx[3:0];
                    end
                end
                if (better) begin
                    best_hash <= mem_read_data;
                    best_idx  <= word_idx[3:0];
                end
            end
        end
    end

    // 16-bit add wraps the scan window around the top of the address space.
    assign mem_addr  = base + {{(16-OFFSET_W){1'b0}}, offset};
    assign mem_clk   = clk;
    assign mem_we    = 1'b0;
    assign done      = (state == IDLE);
    assign dbg_state = state;

endmodule : hash_target_checker

// File: tb/tb_hash_target_checker.sv
// Randomized and directed bench for hash_target_checker with a memory model and a
// loop-based reference of the scan results.
module tb_hash_target_checker;
    import hash_target_checker_pkg::*;

    localparam int N = NUM_NONCES_DEFAULT;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [15:0] hash_addr = '0;
    logic [31:0] target = '0;
    logic        done, found, mem_clk, mem_we;
    logic [3:0]  nonce_idx, best_idx;
    logic [31:0] best_hash;
    logic [4:0]  hit_count;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data = '0;
    state_e      dbg_state;

    hash_target_checker #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .hash_addr(hash_addr),
        .target(target), .done(done), .found(found), .nonce_idx(nonce_idx),
        .best_hash(best_hash), .best_idx(best_idx), .hit_count(hit_count),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_read_data(mem_read_data), .dbg_state(dbg_state)
    );

    // one-cycle-latency read memory
    logic [31:0] mem [0:65535];
    always @(posedge clk) mem_read_data <= mem[mem_addr];

    logic [31:0] words [N];
    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_words(input logic [15:0] base);
        for (int k = 0; k < N; k++) mem[base + 16'(k)] = words[k];
    endtask

    // reference: count hits, first hit, minimum (first index on ties)
    task automatic push_model(input logic [31:0] tgt);
        int cnt = 0;
        int first = -1;
        logic [31:0] best = 32'hFFFF_FFFF;
        int bidx = 0;
        for (int k = 0; k < N; k++) begin
            if (words[k] < tgt) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (words[k] < best) begin
                best = words[k];
                bidx = k;
            end
        end
        exp_q.push_back({31'd0, first >= 0});
        exp_q.push_back(first >= 0 ? 32'(first) : 32'd0);
        exp_q.push_back(32'(cnt));
        exp_q.push_back(best);
        exp_q.push_back(32'(bidx));
    endtask

    task automatic check_results(input string tag);
        check_val({tag, ".found"},     {31'd0, found},     exp_q.pop_front());
        check_val({tag, ".nonce_idx"}, {28'd0, nonce_idx}, exp_q.pop_front());
        check_val({tag, ".hit_count"}, {27'd0, hit_count}, exp_q.pop_front());
        check_val({tag, ".best_hash"}, best_hash,          exp_q.pop_front());
        check_val({tag, ".best_idx"},  {28'd0, best_idx},  exp_q.pop_front());
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, ".done"},      {31'd0, done},      32'd1);
        check_val({tag, ".state"},     {31'd0, dbg_state}, {31'd0, IDLE});
        check_val({tag, ".found"},     {31'd0, found},     32'd0);
        check_val({tag, ".nonce_idx"}, {28'd0, nonce_idx}, 32'd0);
        check_val({tag, ".best_hash"}, best_hash,          32'hFFFF_FFFF);
        check_val({tag, ".best_idx"},  {28'd0, best_idx},  32'd0);
        check_val({tag, ".hit_count"}, {27'd0, hit_count}, 32'd0);
        check_val({tag, ".mem_addr"},  {16'd0, mem_addr},  32'd0);
    endtask

    // driver: pulse start, optionally disturb inputs mid-scan, measure latency
    task automatic run_scan(input string tag, input logic [15:0] base, input logic [31:0] tgt,
                            input bit disturb, input bit check_addr);
        int lat = 0;
        write_words(base);
        push_model(tgt);
        hash_addr = base;
        target    = tgt;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({tag, ".busy"}, {31'd0, done}, 32'd0);
        if (check_addr) begin
            check_val({tag, ".addr0"}, {16'd0, mem_addr}, {16'd0, base});
            check_val({tag, ".we0"}, {31'd0, mem_we}, 32'd0);
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            lat = c;
            if (disturb && c == 5) begin
                start     = 1'b1;
                hash_addr = 16'($urandom);
                target    = $urandom;
            end
            if (disturb && c == 6) start = 1'b0;
            if (check_addr && c < N) begin
                check_val($sformatf("%s.addr%0d", tag, c), {16'd0, mem_addr}, {16'd0, base + 16'(c)});
                check_val($sformatf("%s.we%0d", tag, c), {31'd0, mem_we}, 32'd0);
            end
            if (done) break;
        end
        check_val({tag, ".latency"}, 32'(lat), 32'(N + 1));
        check_results(tag);
    endtask

    initial begin
        logic [31:0] tgt;
        for (int k = 0; k < N; k++) words[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // all words above target
        for (int k = 0; k < N; k++) words[k] = 32'h8000_0000;
        run_scan("none", 16'h0100, 32'h0000_1000, 1'b0, 1'b0);

        // two hits, the later one is smaller
        for (int k = 0; k < N; k++) words[k] = 32'hFFFF_FFFF;
        words[5] = 32'h0000_0FFF;
        words[9] = 32'h0000_0001;
        run_scan("two_hits", 16'h0200, 32'h0000_1000, 1'b0, 1'b0);

        // results hold in IDLE
        repeat (4) @(posedge clk);
        #1;
        push_model(32'h0000_1000);
        check_results("hold");

        // equality is not a hit
        tgt = 32'h0001_2345;
        for (int k = 0; k < N; k++) words[k] = tgt + 32'($urandom_range(1, 1000));
        words[3] = tgt;
        run_scan("equal", 16'h0300, tgt, 1'b0, 1'b0);

        // start/inputs disturbed mid-scan, then back-to-back start
        for (int k = 0; k < N; k++) words[k] = 32'($urandom_range(0, 7));
        run_scan("ignore", 16'h0400, 32'd4, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) words[k] = 32'($urandom_range(0, 7));
        run_scan("b2b", 16'h0500, 32'd3, 1'b0, 1'b0);

        // address wrap
        for (int k = 0; k < N; k++) words[k] = $urandom;
        run_scan("wrap", 16'hFFFA, $urandom, 1'b0, 1'b1);

        // reset at offset 8 with early hits pending
        for (int k = 0; k < N; k++) words[k] = 32'($urandom_range(0, 3));
        write_words(16'h0600);
        hash_addr = 16'h0600;
        target    = 32'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("abort.state", {31'd0, dbg_state}, {31'd0, SCAN});
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_values("abort_in");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("abort_out");
        run_scan("rerun", 16'h0600, 32'd2, 1'b0, 1'b0);

        // randomized scans
        for (int r = 0; r < 12; r++) begin
            case (r % 3)
                0: begin
                    for (int k = 0; k < N; k++) words[k] = $urandom;
                    tgt = $urandom;
                end
                1: begin
                    for (int k = 0; k < N; k++) words[k] = 32'($urandom_range(0, 7));
                    tgt = 32'($urandom_range(0, 8));
                end
                default: begin
                    tgt = $urandom_range(32'h100, 32'hFFFF_FF00);
                    for (int k = 0; k < N; k++) words[k] = tgt - 32'd2 + 32'($urandom_range(0, 4));
                end
            endcase
            run_scan($sformatf("rand%0d", r), 16'($urandom), tgt, r[0], 1'b0);
            if (r % 4 == 3) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hash_target_checker
